sobel_gradient: RTL and testbench

Pipelined Sobel kernel that computes the horizontal and vertical gradient components of one 3x3 pixel window per cycle. It is the producer side of the gx/gy valid/ready interface: its outputs feed the magnitude combiner directly. It outputs absolute, scaled and saturated components plus sign flags, which the later direction/NMS logic uses.

---
 rtl/sobel_pkg.sv | 51 +++++
 rtl/sobel_gradient_pipe_reg.sv | 36 +++
 rtl/sobel_gradient.sv | 95 +++++++++
 tb/tb_sobel_gradient.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants, window unpacking and saturation helpers for the Sobel gradient pipeline.
// Pixel widths up to PIX_W_MAX are supported; narrower pixels use the low bits of each helper.
package sobel_pkg;

    localparam int PIX_W_MAX = 16;

    localparam int P00 = 0;
    localparam int P01 = 1;
    localparam int P02 = 2;
    localparam int P10 = 3;
    localparam int P11 = 4;
    localparam int P12 = 5;
    localparam int P20 = 6;
    localparam int P21 = 7;
    localparam int P22 = 8;

    typedef struct packed {
        logic                 neg;
        logic [PIX_W_MAX-1:0] mag;
    } grad_t;

    function automatic logic [PIX_W_MAX-1:0] get_pixel(
        input logic [9*PIX_W_MAX-1:0] win,
        input int                     idx,
        input int                     w
    );
        logic [9*PIX_W_MAX-1:0] sh;
        logic [PIX_W_MAX-1:0]   mask;
        sh   = win >> (idx * w);
        mask = PIX_W_MAX'((1 << w) - 1);
        return sh[PIX_W_MAX-1:0] & mask;
    endfunction

    // Magnitude fits in w+2 bits; anything left above w-1 after the shift clamps to full scale.
    function automatic grad_t sat_grad(
        input logic                 neg,
        input logic [PIX_W_MAX+1:0] abs_v,
        input int                   shift,
        input int                   w
    );
        logic [PIX_W_MAX+1:0] sh;
        logic [PIX_W_MAX+1:0] lim;
        grad_t                g;
        sh    = abs_v >> shift;
        lim   = (PIX_W_MAX+2)'((1 << w) - 1);
        g.neg = neg;
        g.mag = (sh > lim) ? lim[PIX_W_MAX-1:0] : sh[PIX_W_MAX-1:0];
        return g;
    endfunction

endpackage

// File: rtl/sobel_gradient_pipe_reg.sv
// Elastic pipeline register: loads whenever empty or when downstream drains it,
// otherwise holds data and valid.
module sobel_gradient_pipe_reg #(
    parameter int WIDTH_P = 8
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [WIDTH_P-1:0] data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [WIDTH_P-1:0] data_o,
    output logic               valid_o,
    input  logic               ready_i
);

    logic               en;
    logic               valid_q;
    logic [WIDTH_P-1:0] data_q;

    assign en      = !valid_q || ready_i;
    assign ready_o = en;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (en) begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/sobel_gradient.sv
// Two-stage Sobel kernel: stage 1 holds the positive/negative column and row sums,
// stage 2 holds sign plus shifted, saturated magnitude of Gx and Gy.
module sobel_gradient
    import sobel_pkg::*;
#(
    parameter int WIDTH_P = 8,
    parameter int SHIFT_P = 0
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [9*WIDTH_P-1:0] window_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [WIDTH_P-1:0]   gx_o,
    output logic [WIDTH_P-1:0]   gy_o,
    output logic                 gx_neg_o,
    output logic                 gy_neg_o
);

    localparam int SUM_W = WIDTH_P + 2;
    localparam int S1_W  = 4 * SUM_W;
    localparam int S2_W  = 2 * (WIDTH_P + 1);

    logic [9*PIX_W_MAX-1:0] win_ext;
    logic [WIDTH_P-1:0]     p00, p01, p02, p10, p12, p20, p21, p22;
    logic [SUM_W-1:0]       gx_pos, gx_neg, gy_pos, gy_neg;
    logic [S1_W-1:0]        s1_data_in, s1_data;
    logic                   s1_valid, s2_ready;
    logic [SUM_W-1:0]       s1_gxp, s1_gxn, s1_gyp, s1_gyn;
    logic                   gx_is_neg, gy_is_neg;
    logic [SUM_W-1:0]       gx_abs, gy_abs;
    grad_t                  gx_g, gy_g;
    logic [S2_W-1:0]        s2_data_in, s2_data;
    logic                   unused_mag_bits;

    assign win_ext = (9*PIX_W_MAX)'(window_i);

    // The centre pixel carries zero weight in both kernels.
    assign p00 = WIDTH_P'(get_pixel(win_ext, P00, WIDTH_P));
    assign p01 = WIDTH_P'(get_pixel(win_ext, P01, WIDTH_P));
    assign p02 = WIDTH_P'(get_pixel(win_ext, P02, WIDTH_P));
    assign p10 = WIDTH_P'(get_pixel(win_ext, P10, WIDTH_P));
    assign p12 = WIDTH_P'(get_pixel(win_ext, P12, WIDTH_P));
    assign p20 = WIDTH_P'(get_pixel(win_ext, P20, WIDTH_P));
    assign p21 = WIDTH_P'(get_pixel(win_ext, P21, WIDTH_P));
    assign p22 = WIDTH_P'(get_pixel(win_ext, P22, WIDTH_P));

    assign gx_pos = SUM_W'(p02) + (SUM_W'(p12) << 1) + SUM_W'(p22);
    assign gx_neg = SUM_W'(p00) + (SUM_W'(p10) << 1) + SUM_W'(p20);
    assign gy_pos = SUM_W'(p20) + (SUM_W'(p21) << 1) + SUM_W'(p22);
    assign gy_neg = SUM_W'(p00) + (SUM_W'(p01) << 1) + SUM_W'(p02);

    assign s1_data_in = {gx_pos, gx_neg, gy_pos, gy_neg};

    sobel_gradient_pipe_reg #(.WIDTH_P(S1_W)) u_stage1 (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .data_i  (s1_data_in),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (s1_data),
        .valid_o (s1_valid),
        .ready_i (s2_ready)
    );

    assign {s1_gxp, s1_gxn, s1_gyp, s1_gyn} = s1_data;

    // Comparing the unsigned halves gives the sign directly; equal sums give sign 0.
    assign gx_is_neg = s1_gxp < s1_gxn;
    assign gy_is_neg = s1_gyp < s1_gyn;
    assign gx_abs    = gx_is_neg ? (s1_gxn - s1_gxp) : (s1_gxp - s1_gxn);
    assign gy_abs    = gy_is_neg ? (s1_gyn - s1_gyp) : (s1_gyp - s1_gyn);

    assign gx_g = sat_grad(gx_is_neg, (PIX_W_MAX+2)'(gx_abs), SHIFT_P, WIDTH_P);
    assign gy_g = sat_grad(gy_is_neg, (PIX_W_MAX+2)'(gy_abs), SHIFT_P, WIDTH_P);

    assign s2_data_in      = {gx_g.neg, gx_g.mag[WIDTH_P-1:0], gy_g.neg, gy_g.mag[WIDTH_P-1:0]};
    assign unused_mag_bits = ^{gx_g.mag, gy_g.mag};

    sobel_gradient_pipe_reg #(.WIDTH_P(S2_W)) u_stage2 (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .data_i  (s2_data_in),
        .valid_i (s1_valid),
        .ready_o (s2_ready),
        .data_o  (s2_data),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    assign {gx_neg_o, gx_o, gy_neg_o, gy_o} = s2_data;

endmodule

// File: tb/tb_sobel_gradient.sv
// Directed and streamed checks of sobel_gradient at SHIFT_P=0, with a SHIFT_P=2 twin in lockstep.
`timescale 1ns/1ps
module tb_sobel_gradient;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b1;
    logic [71:0] window_i = '0;
    logic        ready_o, valid_o, gx_neg_o, gy_neg_o;
    logic [7:0]  gx_o, gy_o;
    logic        ready2_o, valid2_o, gx_neg2_o, gy_neg2_o;
    logic [7:0]  gx2_o, gy2_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [71:0] wins [10000];

    always #5 clk = ~clk;

    sobel_gradient #(.WIDTH_P(8), .SHIFT_P(0)) u_dut (
        .clk_i(clk), .rstn_i(rstn), .valid_i(valid_i), .ready_o(ready_o),
        .window_i(window_i), .valid_o(valid_o), .ready_i(ready_i),
        .gx_o(gx_o), .gy_o(gy_o), .gx_neg_o(gx_neg_o), .gy_neg_o(gy_neg_o)
    );

    sobel_gradient #(.WIDTH_P(8), .SHIFT_P(2)) u_dut_s2 (
        .clk_i(clk), .rstn_i(rstn), .valid_i(valid_i), .ready_o(ready2_o),
        .window_i(window_i), .valid_o(valid2_o), .ready_i(ready_i),
        .gx_o(gx2_o), .gy_o(gy2_o), .gx_neg_o(gx_neg2_o), .gy_neg_o(gy_neg2_o)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [71:0] mk_win(input logic [7:0] a00, a01, a02, a10, a11, a12,
                                           a20, a21, a22);
        return {a22, a21, a20, a12, a11, a10, a02, a01, a00};
    endfunction

    // Reference: returns {gx_neg, gx, gy_neg, gy}.
    function automatic logic [17:0] ref_out(input logic [71:0] w, input int sh);
        int p [9];
        int gx, gy, ax, ay;
        for (int i = 0; i < 9; i++) p[i] = int'(w[i*8 +: 8]);
        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        ax = ((gx < 0) ? -gx : gx) >> sh;
        ay = ((gy < 0) ? -gy : gy) >> sh;
        if (ax > 255) ax = 255;
        if (ay > 255) ay = 255;
        return {gx < 0, 8'(ax), gy < 0, 8'(ay)};
    endfunction

    task automatic directed(input string tag, input logic [71:0] w,
                            input int egx, input int egxn, input int egy, input int egyn,
                            input int egx2, input int egy2);
        @(negedge clk);
        ready_i  = 1'b1;
        valid_i  = 1'b1;
        window_i = w;
        @(negedge clk);
        valid_i  = 1'b0;
        window_i = '0;
        check_val({tag, "/lat1_valid"}, 32'(valid_o), 32'd0);
        @(negedge clk);
        check_val({tag, "/lat2_valid"}, 32'(valid_o), 32'd1);
        check_val({tag, "/gx"},     32'(gx_o),     32'(egx));
        check_val({tag, "/gx_neg"}, 32'(gx_neg_o), 32'(egxn));
        check_val({tag, "/gy"},     32'(gy_o),     32'(egy));
        check_val({tag, "/gy_neg"}, 32'(gy_neg_o), 32'(egyn));
        check_val({tag, "/gx_sh2"}, 32'(gx2_o),    32'(egx2));
        check_val({tag, "/gy_sh2"}, 32'(gy2_o),    32'(egy2));
    endtask

    // mode 0: ready_i low for cycles 1..6, valid_i always on; mode 1: random toggling.
    task automatic stream(input string tag, input int n, input int mode);
        int   sent = 0;
        int   got  = 0;
        int   cyc  = 0;
        logic in_fire, out_fire;
        while (got < n && cyc < 8*n + 50) begin
            @(negedge clk);
            if (mode == 0) begin
                ready_i = !(cyc >= 1 && cyc < 7);
                valid_i = (sent < n);
            end else begin
                ready_i = ($urandom_range(0, 9) < 7);
                valid_i = (sent < n) && ($urandom_range(0, 9) < 7);
            end
            window_i = valid_i ? wins[sent] : {$urandom(), $urandom(), 8'($urandom())};
            #1;
            in_fire  = valid_i && ready_o;
            out_fire = valid_o && ready_i;
            if (mode == 0) begin
                if (cyc == 6) begin
                    check_val({tag, "/accepted_while_stalled"}, 32'(sent), 32'd2);
                    check_val({tag, "/ready_low"}, 32'(ready_o), 32'd0);
                end
                if (cyc >= 2 && cyc < 7)
                    check_val({tag, "/stall_hold"},
                              32'({valid_o, gx_neg_o, gx_o, gy_neg_o, gy_o}),
                              32'({1'b1, ref_out(wins[0], 0)}));
                if (cyc >= 7 && got < n)
                    check_val({tag, "/rate"}, 32'(valid_o), 32'd1);
            end
            if (out_fire) begin
                check_val({tag, "/out"}, 32'({gx_neg_o, gx_o, gy_neg_o, gy_o}),
                          32'(ref_out(wins[got], 0)));
                check_val({tag, "/out_sh2"}, 32'({valid2_o, gx_neg2_o, gx2_o, gy_neg2_o, gy2_o}),
                          32'({1'b1, ref_out(wins[got], 2)}));
                got++;
            end
            if (in_fire) sent++;
            cyc++;
        end
        check_val({tag, "/count"}, 32'(got), 32'(n));
        @(negedge clk);
        valid_i = 1'b0;
        ready_i = 1'b1;
        #1;
        check_val({tag, "/no_extra"}, 32'(valid_o), 32'd0);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            if (i % 4 == 0) begin
                for (int k = 0; k < 9; k++)
                    wins[i][k*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'hff : 8'h00;
            end else begin
                wins[i] = {$urandom(), $urandom(), 8'($urandom())};
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst/valid_o", 32'(valid_o), 32'd0);
        check_val("rst/ready_o", 32'(ready_o), 32'd1);
        check_val("rst/outputs", 32'({gx_neg_o, gx_o, gy_neg_o, gy_o}), 32'd0);
        rstn = 1'b1;

        directed("flat",     mk_win(100, 100, 100, 100, 100, 100, 100, 100, 100), 0, 0, 0, 0, 0, 0);
        directed("vedge",    mk_win(0, 5, 10, 0, 5, 10, 0, 5, 10), 40, 0, 0, 0, 10, 0);
        directed("vedge_sw", mk_win(10, 5, 0, 10, 5, 0, 10, 5, 0), 40, 1, 0, 0, 10, 0);
        directed("extreme",  mk_win(255, 0, 0, 255, 0, 0, 255, 0, 0), 255, 1, 0, 0, 255, 0);
        directed("hedge",    mk_win(0, 0, 0, 25, 25, 25, 50, 50, 50), 0, 0, 200, 0, 0, 50);
        directed("hsat",     mk_win(0, 0, 0, 0, 0, 0, 255, 255, 255), 0, 0, 255, 0, 0, 255);
        directed("ramp",     mk_win(1, 2, 3, 4, 5, 6, 7, 8, 9), 8, 0, 24, 0, 2, 6);
        directed("corner",   mk_win(50, 0, 0, 0, 0, 0, 0, 0, 0), 50, 1, 50, 1, 12, 12);

        for (int i = 0; i < 5; i++)
            wins[i] = mk_win(8'(10*i), 8'(i), 8'(200 - 30*i), 8'(3*i), 8'd7, 8'(100 + i),
                             8'(i*i), 8'(60 - i), 8'(255 - 40*i));
        stream("bp", 5, 0);

        fill_random(10000);
        stream("rand", 10000, 1);

        @(negedge clk);
        ready_i  = 1'b0;
        valid_i  = 1'b1;
        window_i = mk_win(9, 9, 9, 9, 9, 9, 200, 200, 200);
        @(negedge clk);
        window_i = mk_win(255, 0, 0, 255, 0, 0, 255, 0, 0);
        @(negedge clk);
        valid_i = 1'b0;
        check_val("rst_mid/in_flight", 32'(valid_o), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_val("rst_mid/valid_o", 32'(valid_o), 32'd0);
        check_val("rst_mid/ready_o", 32'(ready_o), 32'd1);
        check_val("rst_mid/outputs", 32'({gx_neg_o, gx_o, gy_neg_o, gy_o}), 32'd0);
        @(negedge clk);
        ready_i = 1'b1;
        rstn    = 1'b1;
        fill_random(40);
        stream("post_rst", 40, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
